// File: rtl/fft_pkg.sv
// Shared helpers for the FFT output path: offset-width function, lane slicing
// and rotation-direction codes.
package fft_pkg;

  localparam logic DIR_SUB = 1'b0;
  localparam logic DIR_ADD = 1'b1;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int p = 1; p < value; p = p * 2) result++;
    return result;
  endfunction

  // Bit offset of lane k inside a packed lane vector.
  function automatic int laneOffset(input int k, input int bitW);
    return k * bitW;
  endfunction

endpackage

// File: rtl/fft_output_rotator_if.sv
// Beat bus of the FFT output rotator: input beat, control, and registered output beat.
interface fft_output_rotator_if #(
  parameter int BIT   = 17,
  parameter int LANES = 4
) ();
  localparam int SEL_W = fft_pkg::clog2(LANES);

  logic                  iVALID;
  logic                  oREADY;
  logic [SEL_W-1:0]      iSEL;
  logic                  iAUTO;
  logic                  iSTART;
  logic                  iDIR;
  logic                  iCONJ;
  logic [LANES*BIT-1:0]  iX_RE;
  logic [LANES*BIT-1:0]  iX_IM;
  logic                  oVALID;
  logic                  iREADY;
  logic [LANES*BIT-1:0]  oY_RE;
  logic [LANES*BIT-1:0]  oY_IM;
  logic [SEL_W-1:0]      oSEL;
  logic                  oSAT;

  modport master (
    output iVALID, iSEL, iAUTO, iSTART, iDIR, iCONJ, iX_RE, iX_IM, iREADY,
    input  oREADY, oVALID, oY_RE, oY_IM, oSEL, oSAT
  );

  modport slave (
    input  iVALID, iSEL, iAUTO, iSTART, iDIR, iCONJ, iX_RE, iX_IM, iREADY,
    output oREADY, oVALID, oY_RE, oY_IM, oSEL, oSAT
  );
endinterface

// File: rtl/fft_lane_rotate.sv
// Combinational lane rotator: Y[k] = X[(k -/+ s) mod LANES], selected by dir.
module fft_lane_rotate
  import fft_pkg::*;
#(
  parameter int BIT   = 17,
  parameter int LANES = 4,
  localparam int SEL_W = clog2(LANES)
) (
  input  logic [LANES*BIT-1:0] x,
  input  logic [SEL_W-1:0]     s,
  input  logic                 dir,
  output logic [LANES*BIT-1:0] y
);

  logic [SEL_W-1:0] srcIdx;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    y      = '0;
    srcIdx = '0;
    for (int k = 0; k < LANES; k++) begin
      // LANES is a power of two, so SEL_W-bit arithmetic wraps modulo LANES.
      srcIdx = (dir == DIR_ADD) ? SEL_W'(k) + s : SEL_W'(k) - s;
      y[laneOffset(k, BIT) +: BIT] = x[laneOffset(int'(srcIdx), BIT) +: BIT];
    end
  end

endmodule

// File: rtl/fft_output_rotator.sv
// Registered FFT output lane rotator with offset counter, optional conjugation
// and a single-register valid/ready stage.
module fft_output_rotator
  import fft_pkg::*;
#(
  parameter int BIT   = 17,
  parameter int LANES = 4,
  localparam int SEL_W = clog2(LANES)
) (
  input logic iCLK,
  input logic iRESET,
  fft_output_rotator_if.slave bus
);

  localparam logic signed [BIT-1:0] IM_MIN = {1'b1, {(BIT-1){1'b0}}};
  localparam logic signed [BIT-1:0] IM_MAX = {1'b0, {(BIT-1){1'b1}}};

  logic [SEL_W-1:0]     cnt;
  logic [SEL_W-1:0]     sel;
  logic                 accept;
  logic [LANES*BIT-1:0] rotRe;
  logic [LANES*BIT-1:0] rotIm;
  logic [LANES*BIT-1:0] imConj;
  logic                 satHit;
  logic signed [BIT-1:0] laneIm;
  logic signed [BIT-1:0] laneOut;

  logic [LANES*BIT-1:0] yRe;
  logic [LANES*BIT-1:0] yIm;
  logic [SEL_W-1:0]     selQ;
  logic                 validQ;
  logic                 satQ;

  assign accept     = bus.iVALID && bus.oREADY;
  assign bus.oREADY = !validQ || bus.iREADY;

  // A start in the same cycle as an auto beat forces that beat onto offset 0.
  always_comb begin
    sel = bus.iSEL;
    if (bus.iAUTO) sel = bus.iSTART ? '0 : cnt;
  end

  fft_lane_rotate #(.BIT(BIT), .LANES(LANES)) u_rotRe (
    .x(bus.iX_RE), .s(sel), .dir(bus.iDIR), .y(rotRe)
  );

  fft_lane_rotate #(.BIT(BIT), .LANES(LANES)) u_rotIm (
    .x(bus.iX_IM), .s(sel), .dir(bus.iDIR), .y(rotIm)
  );

  always_comb begin
    imConj  = rotIm;
    satHit  = 1'b0;
    laneIm  = '0;
    laneOut = '0;
    if (bus.iCONJ) begin
      for (int k = 0; k < LANES; k++) begin
        laneIm = rotIm[laneOffset(k, BIT) +: BIT];
        if (laneIm == IM_MIN) begin
          laneOut = IM_MAX;
          satHit  = 1'b1;
        end else begin
          laneOut = -laneIm;
        end
        imConj[laneOffset(k, BIT) +: BIT] = laneOut;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      cnt <= '0;
      satQ <= 1'b0;
    end else if (bus.iSTART) begin
      cnt  <= (accept && bus.iAUTO) ? SEL_W'(1) : '0;
      satQ <= accept && satHit;
    end else begin
      if (accept && bus.iAUTO) cnt <= cnt + SEL_W'(1);
      if (accept && satHit) satQ <= 1'b1;
    end
  end

  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      yRe    <= '0;
      yIm    <= '0;
      selQ   <= '0;
      validQ <= 1'b0;
    end else if (accept) begin
      yRe    <= rotRe;
      yIm    <= imConj;
      selQ   <= sel;
      validQ <= 1'b1;
    end else if (bus.iREADY) begin
      validQ <= 1'b0;
    end
  end

  assign bus.oY_RE  = yRe;
  assign bus.oY_IM  = yIm;
  assign bus.oSEL   = selQ;
  assign bus.oVALID = validQ;
  assign bus.oSAT   = satQ;

endmodule
